// File: rtl/aes_key_schedule_seq_pkg.sv
// Shared types, key-length tables and GF(2^8) helpers for the sequential AES key schedule.
package aes_key_schedule_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  localparam logic [1:0] KEYLEN_128 = 2'd0;
  localparam logic [1:0] KEYLEN_192 = 2'd1;
  localparam logic [1:0] KEYLEN_256 = 2'd2;

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [3:0] aes_nk(input logic [1:0] len);
    case (len)
      KEYLEN_192: return 4'd6;
      KEYLEN_256: return 4'd8;
      default:    return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] aes_nr(input logic [1:0] len);
    case (len)
      KEYLEN_192: return 4'd12;
      KEYLEN_256: return 4'd14;
      default:    return 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] aes_nw(input logic [1:0] len);
    case (len)
      KEYLEN_192: return 6'd52;
      KEYLEN_256: return 6'd60;
      default:    return 6'd44;
    endcase
  endfunction

  // Past the tenth round constant the index is still live on the last few words; return 0 there.
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    if (idx >= 4'd1 && idx <= 4'd10) return RCON[idx];
    return 8'h00;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// Control, key-load and round-key read bundle between the cipher core and the key schedule.
interface aes_key_schedule_seq_if #(
  parameter int MAX_KEY_BITS = 256
);
  logic                    start;
  logic [1:0]              key_len;
  logic [MAX_KEY_BITS-1:0] key_in;
  logic                    busy;
  logic                    key_ready;
  logic                    start_err;
  logic                    rd_en;
  logic [3:0]              rd_round;
  logic [127:0]            rd_key;
  logic                    rd_valid;

  modport master (
    output start, key_len, key_in, rd_en, rd_round,
    input  busy, key_ready, start_err, rd_key, rd_valid
  );

  modport slave (
    input  start, key_len, key_in, rd_en, rd_round,
    output busy, key_ready, start_err, rd_key, rd_valid
  );
endinterface

// File: rtl/aes_key_schedule_seq_word_gen.sv
// One KeyExpansion step: derives w[i] from w[i-1] and w[i-Nk] using a single 4-byte SubWord.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  import aes_key_schedule_seq_pkg::*;

  logic [7:0] b;

  always_comb begin
    b = gf_inv(a);
    s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_word_gen (
  input  logic [31:0] w_prev,
  input  logic [31:0] w_back,
  input  logic [2:0]  pos,
  input  logic [3:0]  nk,
  input  logic [7:0]  rcon,
  output logic [31:0] w_new
);
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] t;

  assign sub_in = (pos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in[8*g +: 8]),
      .s (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    if (pos == 3'd0)
      t = sub_out ^ {rcon, 24'h000000};
    else if (nk == 4'd8 && pos == 3'd4)
      t = sub_out;
    else
      t = w_prev;
    w_new = w_back ^ t;
  end
endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key schedule: one word per cycle into a register store, read by round.
//   state     | meaning
//   ST_IDLE   | no valid schedule
//   ST_EXPAND | writing w[Nk..Nw-1]
//   ST_READY  | full schedule readable
module aes_key_schedule_seq
  import aes_key_schedule_seq_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_key_schedule_seq_if.slave bus
);
  localparam int NR_MAX = MAX_KEY_BITS / 32 + 6;
  localparam int NW_MAX = 4 * (NR_MAX + 1);
  localparam int NK_MAX = MAX_KEY_BITS / 32;

  state_t      state;
  state_t      state_nx;
  logic [31:0] w [NW_MAX];
  logic [5:0]  i;
  logic [2:0]  pos;
  logic [3:0]  rcon_idx;
  logic [3:0]  nk;
  logic [3:0]  nr;
  logic [5:0]  nw;
  logic [3:0]  nk_in;
  logic        legal;
  logic        accept;
  logic        last_word;
  logic [31:0] w_new;
  logic [5:0]  rd_base;

  assign nk_in     = aes_nk(bus.key_len);
  assign legal     = (bus.key_len != 2'd3) && (int'(nk_in) * 32 <= MAX_KEY_BITS);
  assign accept    = bus.start && !bus.busy && legal;
  assign last_word = (i == nw - 6'd1);
  assign rd_base   = {bus.rd_round, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept)    state_nx = ST_EXPAND;
      ST_EXPAND: if (last_word) state_nx = ST_READY;
      ST_READY:  if (accept)    state_nx = ST_EXPAND;
      default:                  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state == ST_EXPAND);
    bus.key_ready = (state == ST_READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i        <= 6'd0;
      pos      <= 3'd0;
      rcon_idx <= 4'd1;
      nk       <= 4'd4;
      nr       <= 4'd10;
      nw       <= 6'd44;
    end else if (accept) begin
      i        <= 6'(nk_in);
      pos      <= 3'd0;
      rcon_idx <= 4'd1;
      nk       <= nk_in;
      nr       <= aes_nr(bus.key_len);
      nw       <= aes_nw(bus.key_len);
    end else if (state == ST_EXPAND) begin
      i   <= i + 6'd1;
      // Position within the Nk-word group tracks i mod Nk without a divider.
      pos <= (pos == 3'(nk - 4'd1)) ? 3'd0 : pos + 3'd1;
      if (pos == 3'd0) rcon_idx <= rcon_idx + 4'd1;
    end
  end

  aes_key_word_gen u_word_gen (
    .w_prev (w[i - 6'd1]),
    .w_back (w[i - 6'(nk)]),
    .pos    (pos),
    .nk     (nk),
    .rcon   (rcon_of(rcon_idx)),
    .w_new  (w_new)
  );

  // The store is intentionally not reset; key_ready gates every read of it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int k = 0; k < NK_MAX; k++)
          if (k < int'(nk_in)) w[k] <= bus.key_in[MAX_KEY_BITS-1-32*k -: 32];
      end else if (state == ST_EXPAND) begin
        w[i] <= w_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.start_err <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_key    <= 128'h0;
    end else begin
      bus.start_err <= bus.start && !bus.busy && !legal;
      if (bus.rd_en && bus.key_ready && bus.rd_round <= nr) begin
        bus.rd_valid <= 1'b1;
        bus.rd_key   <= {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
      end else begin
        bus.rd_valid <= 1'b0;
        bus.rd_key   <= 128'h0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed FIPS-197 vectors plus corner sequences for the sequential AES key schedule.
module tb_aes_key_schedule_seq;
  localparam int MKB = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_schedule_seq_if #(.MAX_KEY_BITS(MKB)) bus ();

  aes_key_schedule_seq #(.MAX_KEY_BITS(MKB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]   len;
    logic [255:0] key;
    int           lat;
  } key_vec_t;

  typedef struct {
    int           kidx;
    logic [3:0]   round;
    logic         valid;
    logic [127:0] data;
  } rd_vec_t;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  key_vec_t kv [3];
  rd_vec_t  rv [12];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] len, input logic [255:0] key);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.key_len = len;
    bus.key_in  = key;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.key_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic do_read(input logic [3:0] r, output logic v, output logic [127:0] d);
    @(negedge clk);
    bus.rd_en    = 1'b1;
    bus.rd_round = r;
    tick();
    v = bus.rd_valid;
    d = bus.rd_key;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int           n;
    logic         v;
    logic [127:0] d;

    kv[0] = '{2'd0, K128, 40};
    kv[1] = '{2'd1, K192, 46};
    kv[2] = '{2'd2, K256, 52};
    rv[0]  = '{0, 4'd0,  1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    rv[1]  = '{0, 4'd1,  1'b1, 128'ha0fafe1788542cb123a339392a6c7605};
    rv[2]  = '{0, 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    rv[3]  = '{0, 4'd11, 1'b0, 128'h0};
    rv[4]  = '{1, 4'd0,  1'b1, 128'h8e73b0f7da0e6452c810f32b809079e5};
    rv[5]  = '{1, 4'd1,  1'b1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5};
    rv[6]  = '{1, 4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202};
    rv[7]  = '{1, 4'd13, 1'b0, 128'h0};
    rv[8]  = '{2, 4'd0,  1'b1, 128'h603deb1015ca71be2b73aef0857d7781};
    rv[9]  = '{2, 4'd1,  1'b1, 128'h1f352c073b6108d72d9810a30914dff4};
    rv[10] = '{2, 4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e};
    rv[11] = '{2, 4'd15, 1'b0, 128'h0};

    bus.start = 1'b0; bus.key_len = 2'd0; bus.key_in = '0;
    bus.rd_en = 1'b0; bus.rd_round = 4'd0;
    repeat (3) tick();
    chk("reset_busy", 128'(bus.busy), 128'd0);
    chk("reset_key_ready", 128'(bus.key_ready), 128'd0);
    chk("reset_start_err", 128'(bus.start_err), 128'd0);
    chk("reset_rd_valid", 128'(bus.rd_valid), 128'd0);
    chk("reset_rd_key", bus.rd_key, 128'd0);
    @(negedge clk); rst = 1'b0;
    do_read(4'd0, v, d);
    chk("idle_read_valid", 128'(v), 128'd0);

    for (int k = 0; k < 3; k++) begin
      pulse_start(kv[k].len, kv[k].key);
      chk($sformatf("k%0d_busy_after_accept", k), 128'(bus.busy), 128'd1);
      wait_ready(n);
      chk($sformatf("k%0d_latency", k), 128'(n), 128'(kv[k].lat));
      chk($sformatf("k%0d_busy_done", k), 128'(bus.busy), 128'd0);
      for (int j = 0; j < 12; j++) begin
        if (rv[j].kidx == k) begin
          do_read(rv[j].round, v, d);
          chk($sformatf("k%0d_r%0d_valid", k, rv[j].round), 128'(v), 128'(rv[j].valid));
          chk($sformatf("k%0d_r%0d_key", k, rv[j].round), d, rv[j].data);
        end
      end
    end
    tick();
    chk("rd_valid_one_cycle", 128'(bus.rd_valid), 128'd0);

    // Illegal key_len while READY: error pulse, old AES-256 schedule kept.
    pulse_start(2'd3, '0);
    chk("illegal_start_err", 128'(bus.start_err), 128'd1);
    chk("illegal_key_ready", 128'(bus.key_ready), 128'd1);
    chk("illegal_busy", 128'(bus.busy), 128'd0);
    tick();
    chk("illegal_err_pulse_end", 128'(bus.start_err), 128'd0);
    do_read(4'd14, v, d);
    chk("illegal_old_r14", d, 128'hfe4890d1e6188d0b046df344706c631e);

    // start while busy is ignored.
    pulse_start(2'd0, K128);
    repeat (5) tick();
    pulse_start(2'd0, '0);
    chk("busy_start_no_err", 128'(bus.start_err), 128'd0);
    wait_ready(n);
    chk("busy_start_latency", 128'(n + 6), 128'd40);
    do_read(4'd10, v, d);
    chk("busy_start_r10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Read and accepted start on the same edge: old schedule serviced.
    @(negedge clk);
    bus.rd_en = 1'b1; bus.rd_round = 4'd10;
    bus.start = 1'b1; bus.key_len = 2'd2; bus.key_in = K256;
    tick();
    bus.rd_en = 1'b0; bus.start = 1'b0;
    chk("same_edge_valid", 128'(bus.rd_valid), 128'd1);
    chk("same_edge_key", bus.rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("same_edge_busy", 128'(bus.busy), 128'd1);
    repeat (10) tick();
    do_read(4'd0, v, d);
    chk("expand_read_valid", 128'(v), 128'd0);
    chk("expand_read_key", d, 128'd0);
    repeat (8) tick();

    @(negedge clk); rst = 1'b1;
    tick();
    chk("midrst_key_ready", 128'(bus.key_ready), 128'd0);
    chk("midrst_busy", 128'(bus.busy), 128'd0);
    @(negedge clk); rst = 1'b0;
    do_read(4'd0, v, d);
    chk("midrst_read_valid", 128'(v), 128'd0);

    pulse_start(2'd0, '0);
    wait_ready(n);
    chk("zero_latency", 128'(n), 128'd40);
    do_read(4'd10, v, d);
    chk("zero_r10_valid", 128'(v), 128'd1);
    chk("zero_r10_key", d, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
